// File: rtl/aes_pkg.sv
// Shared AES block constants, state-register FSM encoding and beat helpers.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    LOAD,
    HOLD,
    UNLOAD
  } aes_state_io_e;

  function automatic int aes_beats(input int w);
    return AES_BLOCK_W / w;
  endfunction

  function automatic bit aes_legal_w(input int w);
    return (w == 8) || (w == 16) || (w == 32) ||
           (w == 64) || (w == 128);
  endfunction

endpackage

// File: rtl/aes_beat_ctr.sv
// Wrap-at-max beat counter shared by the load and unload streams.
module aes_beat_ctr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt  = cnt_q;
  assign last = (cnt_q == max);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_state_io.sv
// AES state register: streamed load, round write-back, streamed unload.
// Define AES_STATE_ZEROIZE_EN to wipe the state after the last unload beat.
module aes_state_io
  import aes_pkg::*;
#(
  parameter int DIN_W  = 8,
  parameter int DOUT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIN_W-1:0]       in_data,
  output logic                   load_done,
  input  logic [AES_BLOCK_W-1:0] dnext,
  input  logic                   wen,
  output logic [AES_BLOCK_W-1:0] state,
  input  logic                   unload,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DOUT_W-1:0]      out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int BI   = aes_beats(DIN_W);
  localparam int BO   = aes_beats(DOUT_W);
  localparam int BMAX = (BI > BO) ? BI : BO;
  localparam int CW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  if (!aes_legal_w(DIN_W)) begin : g_bad_din
    $error("aes_state_io: illegal DIN_W");
  end
  if (!aes_legal_w(DOUT_W)) begin : g_bad_dout
    $error("aes_state_io: illegal DOUT_W");
  end

  aes_state_io_e          fsm_q, fsm_d;
  logic [AES_BLOCK_W-1:0] state_q, state_d;
  logic                   load_done_q, load_done_d;
  logic [CW-1:0]          cnt, cnt_max;
  logic                   cnt_inc, cnt_last;
  logic [DOUT_W-1:0]      beat;

  // One counter serves both directions; its wrap point follows the FSM.
  assign cnt_max = (fsm_q == UNLOAD) ? CW'(BO - 1) : CW'(BI - 1);

  aes_beat_ctr #(
    .W (CW)
  ) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (cnt_inc),
    .max   (cnt_max),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    load_done_d = 1'b0;
    cnt_inc     = 1'b0;
    if (clr) begin
      fsm_d   = LOAD;
      state_d = '0;
    end else begin
      unique case (fsm_q)
        LOAD: begin
          if (in_valid) begin
            cnt_inc = 1'b1;
            for (int i = 0; i < BI; i++) begin
              if (cnt == CW'(i)) begin
                state_d[AES_BLOCK_W-1-DIN_W*i -: DIN_W] = in_data;
              end
            end
            if (cnt_last) begin
              fsm_d       = HOLD;
              load_done_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (wen) state_d = dnext;
          if (unload) fsm_d = UNLOAD;
        end
        UNLOAD: begin
          if (out_ready) begin
            cnt_inc = 1'b1;
            if (cnt_last) begin
              fsm_d = LOAD;
`ifdef AES_STATE_ZEROIZE_EN
              state_d = '0;
`else
              state_d = state_q;
`endif
            end
          end
        end
        default: fsm_d = LOAD;
      endcase
    end
  end

  always_comb begin
    beat = '0;
    if (fsm_q == UNLOAD) begin
      for (int i = 0; i < BO; i++) begin
        if (cnt == CW'(i)) begin
          beat = state_q[AES_BLOCK_W-1-DOUT_W*i -: DOUT_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= LOAD;
      state_q     <= '0;
      load_done_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      load_done_q <= load_done_d;
    end
  end

  assign state     = state_q;
  assign load_done = load_done_q;
  assign in_ready  = (fsm_q == LOAD);
  assign out_valid = (fsm_q == UNLOAD);
  assign out_last  = (fsm_q == UNLOAD) && cnt_last;
  assign busy      = (fsm_q != LOAD);
  assign out_data  = beat;

endmodule

// File: tb/tb_aes_state_io.sv
// Directed bench for aes_state_io: 8-bit and 32-bit loads, scoreboarded unload.
module tb_aes_state_io;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = '0;
  logic         load_done;
  logic [127:0] dnext = '0;
  logic         wen = 1'b0;
  logic [127:0] state;
  logic         unload = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic         out_last;
  logic         busy;

  logic         b_in_valid = 1'b0;
  logic         b_in_ready;
  logic [31:0]  b_in_data = '0;
  logic         b_load_done;
  logic [127:0] b_state;
  logic         b_out_valid;
  logic [31:0]  b_out_data;
  logic         b_out_last;
  logic         b_busy;

  int passed = 0;
  int total  = 0;
  logic [7:0] sbq[$];

  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] D1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] D2 = 128'hdeadbeefcafef00d0123456789abcdef;
  localparam logic [127:0] P3 = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 clk = ~clk;

  aes_state_io #(.DIN_W(8), .DOUT_W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .load_done (load_done),
    .dnext     (dnext),
    .wen       (wen),
    .state     (state),
    .unload    (unload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  aes_state_io #(.DIN_W(32), .DOUT_W(32)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .load_done (b_load_done),
    .dnext     (128'h0),
    .wen       (1'b0),
    .state     (b_state),
    .unload    (1'b0),
    .out_valid (b_out_valid),
    .out_ready (1'b1),
    .out_data  (b_out_data),
    .out_last  (b_out_last),
    .busy      (b_busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [127:0] blk, input bit gap);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = blk[127-8*i -: 8];
      tick();
      in_valid = 1'b0;
      chk("load_done_pulse", load_done, i == 15);
      if (gap && i < 15) begin
        tick();
        chk("load_done_gap", load_done, 0);
      end
    end
    chk("load_state", state, blk);
    chk("load_busy", busy, 1);
    chk("load_in_ready", in_ready, 0);
    tick();
    chk("load_done_fall", load_done, 0);
  endtask

  task automatic push_blk(input logic [127:0] blk);
    for (int i = 0; i < 16; i++) sbq.push_back(blk[127-8*i -: 8]);
  endtask

  task automatic drain(input bit toggle);
    int c;
    c = 0;
    while (sbq.size() > 0 && c < 64) begin
      out_ready = toggle ? (c % 2 == 0) : 1'b1;
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, sbq[0]);
      chk("out_last", out_last, sbq.size() == 1);
      if (out_ready) void'(sbq.pop_front());
      tick();
      c++;
    end
    out_ready = 1'b0;
    chk("drain_done", 128'(sbq.size()), 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_out_valid", out_valid, 0);
  endtask

  task automatic chk_zeroize(input logic [127:0] blk);
`ifdef AES_STATE_ZEROIZE_EN
    chk("zeroize", state, 128'h0);
`else
    chk("retain", state, blk);
`endif
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_load_done"}, load_done, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_state"}, state, 0);
  endtask

  initial begin
    #12;
    chk_reset_outs("rst");
    chk("rst_b_state", b_state, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    rst_n = 1'b1;
    tick();

    load8(P1, 1'b1);

    wen   = 1'b1;
    dnext = D1;
    tick();
    wen = 1'b0;
    chk("wen_state", state, D1);
    unload = 1'b1;
    tick();
    unload = 1'b0;
    push_blk(D1);
    drain(1'b0);
    chk_zeroize(D1);

    load8(P2, 1'b0);
    wen    = 1'b1;
    dnext  = D2;
    unload = 1'b1;
    tick();
    wen    = 1'b0;
    unload = 1'b0;
    push_blk(D2);
    drain(1'b1);
    chk_zeroize(D2);

    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = P1[127-8*i -: 8];
      tick();
    end
    in_valid = 1'b0;
    clr      = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_state", state, 0);
    chk("clr_load_done", load_done, 0);
    chk("clr_in_ready", in_ready, 1);
    wen   = 1'b1;
    dnext = D1;
    tick();
    wen = 1'b0;
    chk("wen_ignored_load", state, 0);
    load8(P3, 1'b0);

    unload    = 1'b1;
    tick();
    unload    = 1'b0;
    out_ready = 1'b1;
    chk("mid_first_beat", out_data, P3[127 -: 8]);
    tick();
    tick();
    chk("mid_third_beat", out_data, P3[111 -: 8]);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("arst");
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = P1[127-32*i -: 32];
      tick();
      b_in_valid = 1'b0;
      chk("b_load_done", b_load_done, i == 3);
    end
    chk("b_state", b_state, P1);
    chk("b_busy", b_busy, 1);
    tick();
    chk("b_load_done_fall", b_load_done, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
